// File: rtl/dart_field_if.sv
// Bus bundle between dart_field and its neighbours: character position and
// forced-spawn controls in, dart heads and life/status flags out.
interface dart_field_if;
  logic [7:0]  iXchar;
  logic [6:0]  iYchar;
  logic        iSpawnEn;
  logic        iLoadEn;
  logic [14:0] iLoadYX;
  logic [1:0]  iLoadDir;
  logic [14:0] oYX0;
  logic [14:0] oYX1;
  logic [14:0] oYX2;
  logic [14:0] oYX3;
  logic [3:0]  oActive;
  logic        oHit;
  logic [2:0]  oLives;
  logic        oGameOver;

  modport slave (
    input  iXchar, iYchar, iSpawnEn, iLoadEn, iLoadYX, iLoadDir,
    output oYX0, oYX1, oYX2, oYX3, oActive, oHit, oLives, oGameOver
  );

  modport master (
    output iXchar, iYchar, iSpawnEn, iLoadEn, iLoadYX, iLoadDir,
    input  oYX0, oYX1, oYX2, oYX3, oActive, oHit, oLives, oGameOver
  );
endinterface

// File: rtl/dart_field.sv
// Per-frame dart engine: four diagonal dart slots that spawn (forced or
// LFSR-driven), step one pixel per frame, despawn at the screen border and
// cost the player one life per frame in which any of them touches the
// character hitbox. Everything freezes once the lives run out.
module dart_field #(
  parameter int          SPAWN_PERIOD = 8,
  parameter int          LIVES        = 3,
  parameter int          CHAR_W       = 7,
  parameter int          CHAR_H       = 8,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input  logic        frameClock,
  input  logic        iResetn,
  dart_field_if.slave bus
);

  localparam int          CW         = (SPAWN_PERIOD > 1) ? $clog2(SPAWN_PERIOD) : 1;
  localparam logic [CW-1:0] CNT_RELOAD = CW'(SPAWN_PERIOD - 1);
  localparam logic [2:0]  LIVES_INIT = 3'(LIVES);
  localparam logic [8:0]  W_OFF      = 9'(CHAR_W - 1);
  localparam logic [8:0]  H_OFF      = 9'(CHAR_H - 1);
  localparam logic [7:0]  X_MAX      = 8'd159;
  localparam logic [6:0]  Y_MAX      = 7'd119;

  logic [3:0]       act_q, act_d;
  logic [3:0][7:0]  x_q, x_d;
  logic [3:0][6:0]  y_q, y_d;
  logic [3:0][1:0]  dir_q, dir_d;   // {dySign, dxSign}, 1 = decrement
  logic [2:0]       lives_q, lives_d;
  logic             hit_q, hit_d;
  logic             go_q, go_d;
  logic [15:0]      lfsr_q, lfsr_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic [3:0] hit_vec;
  logic [3:0] free_pre;
  logic [3:0] free_auto;
  logic       f_found, a_found;
  logic [1:0] f_idx, a_idx;
  logic [8:0] xc9, yc9, xs9, ys9;
  logic       desp;
  logic [6:0] ay;

  // Next-state: hit -> move/despawn -> forced spawn -> automatic spawn, all
  // from pre-edge values; game-over holds everything.
  always_comb begin
    act_d     = act_q;
    x_d       = x_q;
    y_d       = y_q;
    dir_d     = dir_q;
    lives_d   = lives_q;
    hit_d     = 1'b0;
    go_d      = go_q;
    lfsr_d    = lfsr_q;
    cnt_d     = cnt_q;
    hit_vec   = '0;
    free_pre  = ~act_q;
    free_auto = ~act_q;
    f_found   = 1'b0;
    a_found   = 1'b0;
    f_idx     = '0;
    a_idx     = '0;
    xc9       = {1'b0, bus.iXchar};
    yc9       = {2'b00, bus.iYchar};
    xs9       = '0;
    ys9       = '0;
    desp      = 1'b0;
    ay        = '0;

    if (!go_q) begin
      // 9-bit compares so iXchar+CHAR_W-1 cannot wrap past 255
      for (int i = 0; i < 4; i++) begin
        xs9 = {1'b0, x_q[i]};
        ys9 = {2'b00, y_q[i]};
        hit_vec[i] = act_q[i] && (xc9 <= xs9) && (xs9 <= xc9 + W_OFF)
                              && (yc9 <= ys9) && (ys9 <= yc9 + H_OFF);
      end

      for (int i = 0; i < 4; i++) begin
        if (act_q[i]) begin
          // out-of-range forced loads fall out on their first move
          desp = (x_q[i] > X_MAX) || (y_q[i] > Y_MAX)
              || (!dir_q[i][0] && x_q[i] == X_MAX) || (dir_q[i][0] && x_q[i] == 8'd0)
              || (!dir_q[i][1] && y_q[i] == Y_MAX) || (dir_q[i][1] && y_q[i] == 7'd0);
          if (hit_vec[i] || desp) begin
            act_d[i] = 1'b0;
          end else begin
            x_d[i] = dir_q[i][0] ? x_q[i] - 8'd1 : x_q[i] + 8'd1;
            y_d[i] = dir_q[i][1] ? y_q[i] - 7'd1 : y_q[i] + 7'd1;
          end
        end
      end

      // lowest pre-edge free slot; slots freed this edge stay out
      for (int i = 3; i >= 0; i--) begin
        if (free_pre[i]) begin
          f_found = 1'b1;
          f_idx   = 2'(i);
        end
      end
      if (bus.iLoadEn && f_found) begin
        act_d[f_idx]     = 1'b1;
        x_d[f_idx]       = bus.iLoadYX[7:0];
        y_d[f_idx]       = bus.iLoadYX[14:8];
        dir_d[f_idx]     = bus.iLoadDir;
        free_auto[f_idx] = 1'b0;
      end

      for (int i = 3; i >= 0; i--) begin
        if (free_auto[i]) begin
          a_found = 1'b1;
          a_idx   = 2'(i);
        end
      end
      ay = (lfsr_q[8:2] > Y_MAX) ? lfsr_q[8:2] - 7'd8 : lfsr_q[8:2];
      if (cnt_q == '0) begin
        cnt_d = CNT_RELOAD;
        if (bus.iSpawnEn && a_found) begin
          act_d[a_idx] = 1'b1;
          dir_d[a_idx] = lfsr_q[1:0];
          x_d[a_idx]   = lfsr_q[0] ? X_MAX : 8'd0;
          y_d[a_idx]   = ay;
        end
      end else begin
        cnt_d = cnt_q - CW'(1);
      end

      lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

      // one life per frame no matter how many darts land
      if (|hit_vec) begin
        hit_d   = 1'b1;
        lives_d = lives_q - 3'd1;
        if (lives_q == 3'd1) go_d = 1'b1;
      end
    end
  end

  // State registers with immediate asynchronous reset.
  always_ff @(posedge frameClock or negedge iResetn) begin
    if (!iResetn) begin
      act_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      dir_q   <= '0;
      lives_q <= LIVES_INIT;
      hit_q   <= 1'b0;
      go_q    <= 1'b0;
      lfsr_q  <= LFSR_SEED;
      cnt_q   <= CNT_RELOAD;
    end else begin
      act_q   <= act_d;
      x_q     <= x_d;
      y_q     <= y_d;
      dir_q   <= dir_d;
      lives_q <= lives_d;
      hit_q   <= hit_d;
      go_q    <= go_d;
      lfsr_q  <= lfsr_d;
      cnt_q   <= cnt_d;
    end
  end

  // Inactive slots show 7FFF so the compositor never matches them.
  always_comb begin
    bus.oYX0      = act_q[0] ? {y_q[0], x_q[0]} : 15'h7FFF;
    bus.oYX1      = act_q[1] ? {y_q[1], x_q[1]} : 15'h7FFF;
    bus.oYX2      = act_q[2] ? {y_q[2], x_q[2]} : 15'h7FFF;
    bus.oYX3      = act_q[3] ? {y_q[3], x_q[3]} : 15'h7FFF;
    bus.oActive   = act_q;
    bus.oHit      = hit_q;
    bus.oLives    = lives_q;
    bus.oGameOver = go_q;
  end

endmodule
